// File: rtl/snake_pkg.sv
// Shared widths, apple reset position and controller state encoding for the snake game.
package snake_pkg;

  localparam int X_W = 10;
  localparam int Y_W = 9;

  localparam logic [X_W-1:0] APPLE_RST_X = 10'd70;
  localparam logic [Y_W-1:0] APPLE_RST_Y = 9'd90;

  typedef enum logic [1:0] {
    SAMPLE,
    ARMED,
    UPD_HI,
    UPD_LO
  } state_t;

endpackage

// File: rtl/box_hit.sv
// Combinational square-overlap test: hit when both |dx| and |dy| are below SIZE.
module box_hit
  import snake_pkg::*;
#(
  parameter int SIZE = 10
) (
  input  logic [X_W-1:0] a_x,
  input  logic [Y_W-1:0] a_y,
  input  logic [X_W-1:0] b_x,
  input  logic [Y_W-1:0] b_y,
  output logic           hit
);

  logic [X_W-1:0] dx;
  logic [Y_W-1:0] dy;

  // Subtract smaller from larger so the distance never wraps.
  always_comb begin
    dx  = (a_x >= b_x) ? (a_x - b_x) : (b_x - a_x);
    dy  = (a_y >= b_y) ? (a_y - b_y) : (b_y - a_y);
    hit = (32'(dx) < SIZE) && (32'(dy) < SIZE);
  end

endmodule

// File: rtl/apple_eat_ctrl.sv
// Apple consumer: latches generator X/Y, checks head collision on move ticks, requests a respawn.
// Optional macro APPLE_SPAWN_CHECK_EN rejects freshly sampled apples that land on the head.
module apple_eat_ctrl
  import snake_pkg::*;
#(
  parameter int APPLE_SIZE = 10,
  parameter int UPD_HOLD   = 4,
  parameter int SCORE_W    = 8
`ifdef APPLE_SPAWN_CHECK_EN
  ,
  parameter int MAX_RETRY  = 15
`endif
) (
  input  logic               VGA_clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               move_tick,
  input  logic [X_W-1:0]     head_X,
  input  logic [Y_W-1:0]     head_Y,
  input  logic [X_W-1:0]     rand_X,
  input  logic [Y_W-1:0]     rand_Y,
  output logic               update,
  output logic [X_W-1:0]     apple_X,
  output logic [Y_W-1:0]     apple_Y,
  output logic               apple_valid,
  output logic               grow,
  output logic [SCORE_W-1:0] score
);

  localparam int CNT_W = $clog2(UPD_HOLD + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(UPD_HOLD - 1);

  state_t               state_reg, state_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic                 update_reg, update_next;
  logic [X_W-1:0]       apple_x_reg, apple_x_next;
  logic [Y_W-1:0]       apple_y_reg, apple_y_next;
  logic                 valid_reg, valid_next;
  logic                 grow_reg, grow_next;
  logic [SCORE_W-1:0]   score_reg, score_next;
  logic [X_W-1:0]       chk_x;
  logic [Y_W-1:0]       chk_y;
  logic                 hit;

`ifdef APPLE_SPAWN_CHECK_EN
  localparam int RETRY_W = $clog2(MAX_RETRY + 1);
  logic [RETRY_W-1:0]   retry_reg, retry_next;

  // One comparator serves both checks: candidate sample in SAMPLE, live apple elsewhere.
  assign chk_x = (state_reg == SAMPLE) ? rand_X : apple_x_reg;
  assign chk_y = (state_reg == SAMPLE) ? rand_Y : apple_y_reg;
`else
  assign chk_x = apple_x_reg;
  assign chk_y = apple_y_reg;
`endif

  box_hit #(.SIZE(APPLE_SIZE)) u_box_hit (
    .a_x (head_X),
    .a_y (head_Y),
    .b_x (chk_x),
    .b_y (chk_y),
    .hit (hit)
  );

  always_ff @(posedge VGA_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= SAMPLE;
      cnt_reg     <= '0;
      update_reg  <= 1'b0;
      apple_x_reg <= APPLE_RST_X;
      apple_y_reg <= APPLE_RST_Y;
      valid_reg   <= 1'b0;
      grow_reg    <= 1'b0;
      score_reg   <= '0;
`ifdef APPLE_SPAWN_CHECK_EN
      retry_reg   <= '0;
`endif
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      update_reg  <= update_next;
      apple_x_reg <= apple_x_next;
      apple_y_reg <= apple_y_next;
      valid_reg   <= valid_next;
      grow_reg    <= grow_next;
      score_reg   <= score_next;
`ifdef APPLE_SPAWN_CHECK_EN
      retry_reg   <= retry_next;
`endif
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    update_next  = update_reg;
    apple_x_next = apple_x_reg;
    apple_y_next = apple_y_reg;
    valid_next   = valid_reg;
    grow_next    = 1'b0;
    score_next   = score_reg;
`ifdef APPLE_SPAWN_CHECK_EN
    retry_next   = retry_reg;
`endif
    case (state_reg)
      SAMPLE: begin
`ifdef APPLE_SPAWN_CHECK_EN
        if (hit && (retry_reg != RETRY_W'(MAX_RETRY))) begin
          retry_next = retry_reg + 1'b1;
        end else begin
          apple_x_next = rand_X;
          apple_y_next = rand_Y;
          valid_next   = 1'b1;
          state_next   = ARMED;
        end
`else
        apple_x_next = rand_X;
        apple_y_next = rand_Y;
        valid_next   = 1'b1;
        state_next   = ARMED;
`endif
      end
      ARMED: begin
        if (move_tick && enable && hit) begin
          grow_next   = 1'b1;
          if (score_reg != '1) score_next = score_reg + 1'b1;
          valid_next  = 1'b0;
          update_next = 1'b1;
          cnt_next    = '0;
          state_next  = UPD_HI;
        end
      end
      UPD_HI: begin
        if (cnt_reg == CNT_LAST) begin
          cnt_next    = '0;
          update_next = 1'b0;
          state_next  = UPD_LO;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      UPD_LO: begin
        // Low phase gives the generator time to settle its new Y before resampling.
        if (cnt_reg == CNT_LAST) begin
          cnt_next   = '0;
          state_next = SAMPLE;
`ifdef APPLE_SPAWN_CHECK_EN
          retry_next = '0;
`endif
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = SAMPLE;
    endcase
  end

  assign update      = update_reg;
  assign apple_X     = apple_x_reg;
  assign apple_Y     = apple_y_reg;
  assign apple_valid = valid_reg;
  assign grow        = grow_reg;
  assign score       = score_reg;

endmodule

// File: tb/tb_apple_eat_ctrl.sv
// Directed scoreboard bench for apple_eat_ctrl (2-bit score to reach saturation quickly).
module tb_apple_eat_ctrl;

  localparam int SW = 2;

  logic          VGA_clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          enable = 1'b1;
  logic          move_tick = 1'b0;
  logic [9:0]    head_X = '0;
  logic [8:0]    head_Y = '0;
  logic [9:0]    rand_X = '0;
  logic [8:0]    rand_Y = '0;
  logic          update;
  logic [9:0]    apple_X;
  logic [8:0]    apple_Y;
  logic          apple_valid;
  logic          grow;
  logic [SW-1:0] score;

  apple_eat_ctrl #(.APPLE_SIZE(10), .UPD_HOLD(4), .SCORE_W(SW)) dut (
    .VGA_clk     (VGA_clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .move_tick   (move_tick),
    .head_X      (head_X),
    .head_Y      (head_Y),
    .rand_X      (rand_X),
    .rand_Y      (rand_Y),
    .update      (update),
    .apple_X     (apple_X),
    .apple_Y     (apple_Y),
    .apple_valid (apple_valid),
    .grow        (grow),
    .score       (score)
  );

  always #5 VGA_clk = ~VGA_clk;

  typedef struct {
    logic          grow;
    logic [SW-1:0] score;
    logic          upd;
  } tick_exp_t;

  typedef struct {
    int x;
    int y;
  } apple_exp_t;

  tick_exp_t  tick_q[$];
  apple_exp_t apple_q[$];

  int errors = 0;
  int checks = 0;
  int m_ax, m_ay, m_score;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Starts and ends at a falling edge; returns whether the model expected a hit.
  task automatic tick(input int hx, input int hy, input logic en, output logic was_hit);
    int dx, dy;
    tick_exp_t e, g;
    dx = (hx > m_ax) ? hx - m_ax : m_ax - hx;
    dy = (hy > m_ay) ? hy - m_ay : m_ay - hy;
    was_hit = en && (dx < 10) && (dy < 10);
    if (was_hit && m_score < 3) m_score++;
    e.grow = was_hit; e.score = SW'(m_score); e.upd = was_hit;
    tick_q.push_back(e);
    head_X = 10'(hx); head_Y = 9'(hy); enable = en; move_tick = 1'b1;
    @(posedge VGA_clk); #1;
    if (tick_q.size() == 0) begin
      check("tick_q_empty", 1, 0);
    end else begin
      g = tick_q.pop_front();
      check("tick_grow", 32'(grow), 32'(g.grow));
      check("tick_score", 32'(score), 32'(g.score));
      check("tick_update", 32'(update), 32'(g.upd));
      check("tick_valid", 32'(apple_valid), 32'(!g.upd));
    end
    $display("tick head=(%0d,%0d) en=%0b grow=%0b score=%0d update=%0b", hx, hy, en, grow, score, update);
    @(negedge VGA_clk);
    move_tick = 1'b0;
    enable = 1'b1;
  endtask

  // Walks the update-high / update-low / resample sequence that follows a hit.
  task automatic spawn(input int nx, input int ny, input logic overlap);
    apple_exp_t a;
    a.x = nx; a.y = ny;
    apple_q.push_back(a);
    rand_X = 10'(nx); rand_Y = 9'(ny);
    for (int i = 1; i <= 3; i++) begin
      if (overlap && i == 1) begin
        head_X = 10'(m_ax); head_Y = 9'(m_ay); move_tick = 1'b1;
      end
      @(posedge VGA_clk); #1;
      check("hi_update", 32'(update), 1);
      check("hi_grow", 32'(grow), 0);
      check("hi_score", 32'(score), 32'(m_score));
      @(negedge VGA_clk);
      move_tick = 1'b0;
    end
    for (int i = 4; i <= 8; i++) begin
      @(posedge VGA_clk); #1;
      check("lo_update", 32'(update), 0);
      check("lo_valid", 32'(apple_valid), 0);
      @(negedge VGA_clk);
    end
    @(posedge VGA_clk); #1;
    check("resample_valid", 32'(apple_valid), 1);
    if (apple_q.size() == 0) begin
      check("apple_q_empty", 1, 0);
    end else begin
      a = apple_q.pop_front();
      check("resample_x", 32'(apple_X), 32'(a.x));
      check("resample_y", 32'(apple_Y), 32'(a.y));
      m_ax = a.x; m_ay = a.y;
    end
    $display("spawn apple=(%0d,%0d) valid=%0b", apple_X, apple_Y, apple_valid);
    @(negedge VGA_clk);
  endtask

  initial begin
    logic h;
    m_score = 0;
    rand_X = 10'd100; rand_Y = 9'd200;
    #1 rst_n = 1'b0;
    #12;
    check("rst_update", 32'(update), 0);
    check("rst_apple_x", 32'(apple_X), 70);
    check("rst_apple_y", 32'(apple_Y), 90);
    check("rst_valid", 32'(apple_valid), 0);
    check("rst_grow", 32'(grow), 0);
    check("rst_score", 32'(score), 0);
    $display("reset update=%0b apple=(%0d,%0d) valid=%0b score=%0d", update, apple_X, apple_Y, apple_valid, score);

    @(negedge VGA_clk);
    rst_n = 1'b1;
    @(posedge VGA_clk); #1;
    check("first_x", 32'(apple_X), 100);
    check("first_y", 32'(apple_Y), 200);
    check("first_valid", 32'(apple_valid), 1);
    check("first_score", 32'(score), 0);
    $display("release apple=(%0d,%0d) valid=%0b", apple_X, apple_Y, apple_valid);
    m_ax = 100; m_ay = 200;
    @(negedge VGA_clk);

    tick(105, 195, 1'b1, h); check("hit1_model", 32'(h), 1);
    spawn(300, 100, 1'b1);
    tick(310, 100, 1'b1, h);   // dx equals APPLE_SIZE: miss
    tick(300, 110, 1'b1, h);   // dy equals APPLE_SIZE: miss
    tick(305, 105, 1'b0, h);   // disabled: miss
    tick(295, 95, 1'b1, h);
    spawn(50, 50, 1'b0);
    tick(50, 50, 1'b1, h);
    spawn(400, 300, 1'b0);
    tick(409, 291, 1'b1, h);   // score saturates, grow still pulses
    spawn(200, 400, 1'b0);
    tick(191, 409, 1'b1, h);

    // Reset asserted in the middle of the update-high phase.
    rand_X = 10'd12; rand_Y = 9'd34;
    @(posedge VGA_clk); #1;
    check("pre_rst_update", 32'(update), 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_update", 32'(update), 0);
    check("mid_rst_score", 32'(score), 0);
    check("mid_rst_x", 32'(apple_X), 70);
    check("mid_rst_valid", 32'(apple_valid), 0);
    $display("mid reset update=%0b score=%0d", update, score);
    @(negedge VGA_clk);
    rst_n = 1'b1;
    @(posedge VGA_clk); #1;
    check("restart_x", 32'(apple_X), 12);
    check("restart_y", 32'(apple_Y), 34);
    check("restart_valid", 32'(apple_valid), 1);
    $display("restart apple=(%0d,%0d) valid=%0b", apple_X, apple_Y, apple_valid);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
